booth_mul: RTL and testbench
============================

# booth_mul

Unsigned 32×32→64 multiplier built on radix-4 (modified) Booth recoding, with a partial-product compression tree and a registered 64-bit product. It is the multiply datapath block of the processor's execute stage. It also exposes its first 16 aligned partial products as combinational debug outputs.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit product.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  32  multiplicand, unsigned.
- b  input  32  multiplier, unsigned; this operand is Booth-recoded.
- m  output  64  registered product a*b (unsigned, full 64 bits).
- shift0 … shift15  output  64 each  combinational aligned partial products PP0…PP15 of the current a, b.

## Operation
- Booth digits, for i = 0…15: d_i = −2·b[2i+1] + b[2i] + b[2i−1], where b[−1] = 0. So d_i ∈ {−2, −1, 0, +1, +2}.
- Encoder outputs per digit: zero, one (±a), two (±2a), neg.
- Partial products, for i = 0…15: PP_i = (d_i · a) as a signed 34-bit value, sign-extended to 64 bits, shifted left 2i, truncated mod 2^64.
  - −a is formed as ~a + 1; ±2a as a shift of ±a.
  - shift_i = PP_i exactly, including all sign-extension ones.
- Correction term PP16 = b[31] ? (a << 32) : 0. It is internal only and is required for correct unsigned results.
- Product: m_next = (PP0 + … + PP15 + PP16) mod 2^64. This equals the exact unsigned product a*b; no overflow is possible.
- Summation uses a carry-save (3:2 / 4:2) tree reducing 17 rows to 2, then one 64-bit carry-propagate adder. The structure is free, but the result must be bit-exact.
- shift0…shift15 and m_next are purely combinational from a and b. No internal state exists other than the m register.

## Timing
- Reset: while rst = 1, m = 64'h0 immediately (asynchronous), regardless of clk.
- shift0…15 are not reset; they always track a, b combinationally.
- Latency is 1 cycle. a, b are sampled at rising edge N, and m shows a*b after edge N, held until the next edge.
- Throughput is one new operand pair per cycle. There is no handshake or valid signal; m always reflects the most recent sampled pair.
- Operands changing between edges affect only shift0…15, never m.
- Reset asserted mid-stream clears m at once. After deassertion, the first edge loads the product of the a, b present at that edge.
- The combinational path a/b → m register must close timing at the system clock. Pipelining beyond 1 cycle is not permitted.

## Test plan
- Reset and zero:
  - Assert rst with a = 5, b = 7 → m = 0 immediately.
  - Release rst and clock once → m = 35.
  - a = 0, b = 0 → m = 0.
- Small operands:
  - a = 1, b = 1 → m = 1, shift0 = 1.
  - a = 2, b = 3 → m = 6, shift0 = 64'hFFFF_FFFF_FFFF_FFFE (d0 = −1), shift1 = 64'h8 (d1 = +1), shift2…15 = 0.
- Mid-range and extremes:
  - a = 1000, b = 2048 → m = 64'h1F_4000.
  - a = 32'hFFFF_FFFF, b = 1 → m = 64'h0000_0000_FFFF_FFFF.
  - a = 65535, b = 65535 → m = 64'hFFFE_0001.
- PP16 correction path: a = 32'hFFFF_FFFF, b = 32'hFFFF_FFFF → m = 64'hFFFF_FFFE_0000_0001. This exercises b[31] = 1.
- Back-to-back: change a, b every cycle for ≥1000 random pairs (including values with bit 31 set). Each m must equal the 64-bit reference product of the pair sampled one edge earlier. Each shift_i must match the PP_i formula.
- Mid-stream reset: assert rst asynchronously between edges during the random stream → m = 0 at once and stays 0 while asserted. The stream resumes correctly on the first edge after release.

Source files
------------

// File: rtl/booth_mul.sv
// Unsigned 32x32->64 multiplier: radix-4 Booth recoding of b, carry-save reduction of
// 17 partial-product rows, one carry-propagate add, registered product.
module booth_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] m,
  output logic [63:0] shift0,
  output logic [63:0] shift1,
  output logic [63:0] shift2,
  output logic [63:0] shift3,
  output logic [63:0] shift4,
  output logic [63:0] shift5,
  output logic [63:0] shift6,
  output logic [63:0] shift7,
  output logic [63:0] shift8,
  output logic [63:0] shift9,
  output logic [63:0] shift10,
  output logic [63:0] shift11,
  output logic [63:0] shift12,
  output logic [63:0] shift13,
  output logic [63:0] shift14,
  output logic [63:0] shift15
);

  // Carry output of a 3:2 compressor, already aligned one bit left.
  function automatic logic [63:0] csa_carry(input logic [63:0] x, input logic [63:0] y,
                                            input logic [63:0] z);
    logic [63:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[62:0], 1'b0};
  endfunction

  // b with the implicit b[-1] = 0 appended so every digit sees a full triplet.
  logic [32:0] b_ext;
  assign b_ext = {b, 1'b0};

  logic [63:0] pp [17];

  for (genvar i = 0; i < 16; i++) begin : g_booth
    logic [2:0]  trip;
    logic        zero;
    logic        one;
    logic        two;
    logic        neg;
    logic [33:0] a_pos;
    logic [33:0] a_sgn;
    logic [33:0] pp_raw;
    logic [63:0] pp_ext;

    assign trip = b_ext[2*i+2 : 2*i];

    always_comb begin
      zero = 1'b0;
      one  = 1'b0;
      two  = 1'b0;
      neg  = 1'b0;
      unique case (trip)
        3'b000, 3'b111: zero = 1'b1;
        3'b001, 3'b010: one  = 1'b1;
        3'b011:         two  = 1'b1;
        3'b100: begin
          two = 1'b1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          one = 1'b1;
          neg = 1'b1;
        end
        default:        zero = 1'b1;
      endcase
    end

    assign a_pos = {2'b00, a};
    assign a_sgn = neg ? (~a_pos + 34'd1) : a_pos;

    always_comb begin
      pp_raw = '0;
      if (!zero) begin
        if (two) begin
          pp_raw = {a_sgn[32:0], 1'b0};
        end else if (one) begin
          pp_raw = a_sgn;
        end
      end
    end

    assign pp_ext = {{30{pp_raw[33]}}, pp_raw};
    assign pp[i]  = pp_ext << (2 * i);
  end : g_booth

  // Signed recoding treats b as two's complement; add a*2^32 back when b[31] is set.
  assign pp[16] = b[31] ? {a, 32'h0} : 64'h0;

  assign shift0  = pp[0];
  assign shift1  = pp[1];
  assign shift2  = pp[2];
  assign shift3  = pp[3];
  assign shift4  = pp[4];
  assign shift5  = pp[5];
  assign shift6  = pp[6];
  assign shift7  = pp[7];
  assign shift8  = pp[8];
  assign shift9  = pp[9];
  assign shift10 = pp[10];
  assign shift11 = pp[11];
  assign shift12 = pp[12];
  assign shift13 = pp[13];
  assign shift14 = pp[14];
  assign shift15 = pp[15];

  // Reduction: 17 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
  logic [63:0] l1 [12];
  logic [63:0] l2 [8];
  logic [63:0] l3 [6];
  logic [63:0] l4 [4];
  logic [63:0] l5 [3];
  logic [63:0] l6 [2];

  for (genvar k = 0; k < 5; k++) begin : g_l1
    assign l1[2*k]   = pp[3*k] ^ pp[3*k+1] ^ pp[3*k+2];
    assign l1[2*k+1] = csa_carry(pp[3*k], pp[3*k+1], pp[3*k+2]);
  end : g_l1
  assign l1[10] = pp[15];
  assign l1[11] = pp[16];

  for (genvar k = 0; k < 4; k++) begin : g_l2
    assign l2[2*k]   = l1[3*k] ^ l1[3*k+1] ^ l1[3*k+2];
    assign l2[2*k+1] = csa_carry(l1[3*k], l1[3*k+1], l1[3*k+2]);
  end : g_l2

  for (genvar k = 0; k < 2; k++) begin : g_l3
    assign l3[2*k]   = l2[3*k] ^ l2[3*k+1] ^ l2[3*k+2];
    assign l3[2*k+1] = csa_carry(l2[3*k], l2[3*k+1], l2[3*k+2]);
  end : g_l3
  assign l3[4] = l2[6];
  assign l3[5] = l2[7];

  for (genvar k = 0; k < 2; k++) begin : g_l4
    assign l4[2*k]   = l3[3*k] ^ l3[3*k+1] ^ l3[3*k+2];
    assign l4[2*k+1] = csa_carry(l3[3*k], l3[3*k+1], l3[3*k+2]);
  end : g_l4

  assign l5[0] = l4[0] ^ l4[1] ^ l4[2];
  assign l5[1] = csa_carry(l4[0], l4[1], l4[2]);
  assign l5[2] = l4[3];

  assign l6[0] = l5[0] ^ l5[1] ^ l5[2];
  assign l6[1] = csa_carry(l5[0], l5[1], l5[2]);

  logic [63:0] m_d;
  logic [63:0] m_q;

  assign m_d = l6[0] + l6[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= 64'h0;
    end else begin
      m_q <= m_d;
    end
  end

  assign m = m_q;

endmodule

// File: tb/tb_booth_mul.sv
// Randomised self-checking bench for booth_mul: plain-arithmetic product and partial-product
// model, a per-cycle compare process, and literal directed cases.
module tb_booth_mul;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] m;
  logic [63:0] sh [16];

  int checks;
  int failures;
  logic [63:0] exp_m;
  bit chk_en;

  booth_mul dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .m      (m),
    .shift0 (sh[0]),
    .shift1 (sh[1]),
    .shift2 (sh[2]),
    .shift3 (sh[3]),
    .shift4 (sh[4]),
    .shift5 (sh[5]),
    .shift6 (sh[6]),
    .shift7 (sh[7]),
    .shift8 (sh[8]),
    .shift9 (sh[9]),
    .shift10(sh[10]),
    .shift11(sh[11]),
    .shift12(sh[12]),
    .shift13(sh[13]),
    .shift14(sh[14]),
    .shift15(sh[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // PP_i = d_i * a, sign-extended, shifted by 2i, computed with signed integer arithmetic.
  function automatic logic [63:0] pp_ref(input logic [31:0] av, input logic [31:0] bv,
                                         input int i);
    logic [32:0] bx;
    int          d;
    longint      p;
    logic [63:0] r;
    bx = {bv, 1'b0};
    d  = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
    p  = longint'(d) * longint'({32'h0, av});
    r  = p;
    return r << (2 * i);
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 255));
      3:       return $urandom | 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Reference register: product of the pair present at each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_m <= 64'h0;
    else     exp_m <= {32'h0, a} * {32'h0, b};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_stream", m, exp_m);
      for (int i = 0; i < 16; i++) begin
        check($sformatf("shift%0d", i), sh[i], pp_ref(a, b, i));
      end
    end
  end

  task automatic directed(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] req);
    @(negedge clk);
    #1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    check(name, m, req);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    a        = 32'd5;
    b        = 32'd7;
    #1;
    check("reset_async", m, 64'h0);
    @(negedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_5x7", m, 64'd35);

    directed("zero_x_zero", 32'd0, 32'd0, 64'd0);
    directed("one_x_one", 32'd1, 32'd1, 64'd1);
    check("one_x_one_shift0", sh[0], 64'd1);
    directed("two_x_three", 32'd2, 32'd3, 64'd6);
    check("two_x_three_shift0", sh[0], 64'hFFFF_FFFF_FFFF_FFFE);
    check("two_x_three_shift1", sh[1], 64'h8);
    for (int i = 2; i < 16; i++) check($sformatf("two_x_three_shift%0d", i), sh[i], 64'h0);
    directed("1000_x_2048", 32'd1000, 32'd2048, 64'h1F_4000);
    directed("max_x_one", 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);
    directed("ffff_x_ffff", 32'd65535, 32'd65535, 64'hFFFE_0001);
    directed("max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      #1;
      a = rnd_operand();
      b = rnd_operand();
      if (n % 300 == 150) begin
        #3;
        rst = 1'b1;
        #1;
        check("midstream_reset_async", m, 64'h0);
        @(posedge clk);
        #1;
        check("midstream_reset_hold", m, 64'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
